// File: rtl/instruction_prefetch_unit.sv
// Fetch stage: owns the PC, issues word reads to a 1-cycle-latency instruction
// memory and buffers {pc,instr} pairs in a DEPTH-entry FIFO drained by decode.
module instruction_prefetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_en,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   fetch_pc_q;
    logic              inflight_q;
    logic [XLEN-1:0]   req_pc_q;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  occupancy;
    logic [XLEN-1:0]   last_pc_q, last_instr_q;
    logic [XLEN-1:0]   fifo_pc    [DEPTH];
    logic [XLEN-1:0]   fifo_instr [DEPTH];
    logic              push, pop;

    // In-flight reads reserve a FIFO slot so a landing response can never overflow.
    assign occupancy = count_q + CNT_W'(inflight_q);
    assign push      = inflight_q && !redirect_valid;
    assign if_valid  = (count_q != '0);
    assign pop       = if_valid && if_ready;
    assign imem_addr = fetch_pc_q;
    assign if_pc     = if_valid ? fifo_pc[rd_ptr_q]    : last_pc_q;
    assign if_instr  = if_valid ? fifo_instr[rd_ptr_q] : last_instr_q;

    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     imem_req = fetch_en && !redirect_valid && (occupancy < DEPTH_C);
            FLUSH:   state_d = RUN;
            default: state_d = BOOT;
        endcase
        if (redirect_valid) begin
            state_d = FLUSH;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= BOOT;
            fetch_pc_q   <= RESET_PC;
            inflight_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            last_pc_q    <= '0;
            last_instr_q <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= imem_req;
            // A pop seen by decode in the redirect cycle still retires the head.
            if (pop) begin
                last_pc_q    <= fifo_pc[rd_ptr_q];
                last_instr_q <= fifo_instr[rd_ptr_q];
            end
            if (redirect_valid) begin
                fetch_pc_q <= redirect_pc & ~XLEN'(3);
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                count_q    <= '0;
            end else begin
                if (imem_req) begin
                    fetch_pc_q <= fetch_pc_q + XLEN'(4);
                end
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end
                count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (imem_req) begin
            req_pc_q <= fetch_pc_q;
        end
        if (push) begin
            fifo_pc[wr_ptr_q]    <= req_pc_q;
            fifo_instr[wr_ptr_q] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_instruction_prefetch_unit.sv
// Bench for instruction_prefetch_unit: directed scenarios plus random traffic
// compared every cycle against a queue-based reference model.
module tb_instruction_prefetch_unit;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            fetch_en;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_pc;
    logic [XLEN-1:0] if_instr;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t      q[$];
    logic [31:0] m_pc, pend_pc, last_pc, last_instr;
    bit          pend;
    int          quiet;
    int          n_req;
    bit          saw_zero;

    instruction_prefetch_unit #(
        .XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0)
    ) dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_ready(if_ready),
        .if_pc(if_pc), .if_instr(if_instr)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pc       = 32'h0;
        pend       = 1'b0;
        pend_pc    = 32'h0;
        last_pc    = 32'h0;
        last_instr = 32'h0;
        quiet      = 1;
    endtask

    // Asserts reset at the current time (possibly mid-cycle) and releases it.
    task automatic do_reset();
        rst = 1'b1;
        fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b0;
        #1;
        check_eq("rst_req",   imem_req,  0);
        check_eq("rst_addr",  imem_addr, 32'h0);
        check_eq("rst_valid", if_valid,  0);
        check_eq("rst_pc",    if_pc,     32'h0);
        check_eq("rst_instr", if_instr,  32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic step(input bit fe, input bit rv, input logic [31:0] rp, input bit rdy);
        bit     exp_req, exp_vld;
        entry_t e;
        @(negedge clk);
        fetch_en = fe; redirect_valid = rv; redirect_pc = rp; if_ready = rdy;
        imem_rdata = pend ? (pend_pc >> 2) : $urandom;
        #1;
        exp_req = (quiet == 0) && fe && !rv && (q.size() + int'(pend) < DEPTH);
        exp_vld = (q.size() != 0);
        check_eq("imem_req",  imem_req,  exp_req);
        check_eq("imem_addr", imem_addr, m_pc);
        check_eq("if_valid",  if_valid,  exp_vld);
        check_eq("if_pc",     if_pc,     exp_vld ? q[0].pc    : last_pc);
        check_eq("if_instr",  if_instr,  exp_vld ? q[0].instr : last_instr);
        if (imem_req) n_req++;
        if (imem_req && imem_addr == 32'h0) saw_zero = 1'b1;
        if (exp_vld && rdy) begin
            e = q.pop_front();
            last_pc    = e.pc;
            last_instr = e.instr;
        end
        if (rv) begin
            q.delete();
            pend  = 1'b0;
            m_pc  = rp & ~32'h3;
            quiet = 1;
        end else begin
            if (pend) q.push_back({pend_pc, pend_pc >> 2});
            quiet = 0;
            pend  = exp_req;
            if (exp_req) begin
                pend_pc = m_pc;
                m_pc    = m_pc + 32'd4;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        imem_rdata = '0;
        do_reset();

        // Streaming with decode always ready.
        for (int i = 0; i < 12; i++) step(1, 0, 0, 1);

        // Decode stalled: credit limit caps requests at DEPTH, then drain.
        do_reset();
        n_req = 0;
        for (int i = 0; i < 12; i++) step(1, 0, 0, 0);
        check_eq("credit_reqs", n_req, DEPTH);
        for (int i = 0; i < 10; i++) step(1, 0, 0, 1);

        // Redirect with three entries buffered and one read in flight.
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
        check_eq("pre_redir_cnt", q.size(), 3);
        check_eq("pre_redir_pend", pend, 1);
        step(1, 1, 32'h103, 0);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 1);

        // PC wrap at the top of the address space.
        saw_zero = 1'b0;
        step(1, 1, 32'hFFFF_FFF4, 1);
        for (int i = 0; i < 8; i++) step(1, 0, 0, 1);
        check_eq("wrap_seen", saw_zero, 1);

        // Near-full FIFO with simultaneous push and pop.
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);

        // Asynchronous reset in the middle of traffic.
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1);
        @(posedge clk);
        #3;
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 0, 0, 1);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 9) < 8), ($urandom_range(0, 19) == 0),
                 $urandom, ($urandom_range(0, 9) < 7));
            if ($urandom_range(0, 499) == 0) begin
                @(posedge clk);
                #2;
                do_reset();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
